// File: rtl/ysyx_22041207_id_ex_if.sv
// Decode-to-execute bus: decoded fields with their handshake on the input side,
// and the registered operands and controls on the output side.
interface ysyx_22041207_id_ex_if #(
  parameter int DATA_W = 64
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_pc;
  logic [4:0]        in_operate;
  logic [DATA_W-1:0] in_imm;
  logic [DATA_W-1:0] in_csr;
  logic [1:0]        in_sel_a;
  logic [1:0]        in_sel_b;
  logic              in_rs1to32;
  logic [4:0]        in_rs1_addr;
  logic [4:0]        in_rs2_addr;
  logic [4:0]        in_rd;
  logic              in_rd_wen;
  logic [DATA_W-1:0] in_rs1_data;
  logic [DATA_W-1:0] in_rs2_data;

  logic              out_valid;
  logic [DATA_W-1:0] out_pc;
  logic [4:0]        out_operate;
  logic [DATA_W-1:0] out_rs1;
  logic [DATA_W-1:0] out_rs2;
  logic [DATA_W-1:0] out_csr;
  logic [DATA_W-1:0] out_imm;
  logic [1:0]        out_sel_a;
  logic [1:0]        out_sel_b;
  logic              out_rs1to32;
  logic [4:0]        out_rd;
  logic              out_rd_wen;

  modport master (
    output in_valid, in_pc, in_operate, in_imm, in_csr, in_sel_a, in_sel_b, in_rs1to32,
           in_rs1_addr, in_rs2_addr, in_rd, in_rd_wen, in_rs1_data, in_rs2_data,
    input  in_ready,
    input  out_valid, out_pc, out_operate, out_rs1, out_rs2, out_csr, out_imm,
           out_sel_a, out_sel_b, out_rs1to32, out_rd, out_rd_wen
  );

  modport slave (
    input  in_valid, in_pc, in_operate, in_imm, in_csr, in_sel_a, in_sel_b, in_rs1to32,
           in_rs1_addr, in_rs2_addr, in_rd, in_rd_wen, in_rs1_data, in_rs2_data,
    output in_ready,
    output out_valid, out_pc, out_operate, out_rs1, out_rs2, out_csr, out_imm,
           out_sel_a, out_sel_b, out_rs1to32, out_rd, out_rd_wen
  );
endinterface

// File: rtl/ysyx_22041207_id_ex.sv
// ID/EX pipeline register: single-entry hold with load-use stall, EX/MEM operand
// bypass at capture, MEM refresh of a stalled entry, and flush.
module ysyx_22041207_id_ex #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              alu_wait,
  input  logic              ex_fwd_valid,
  input  logic              ex_fwd_is_load,
  input  logic [4:0]        ex_fwd_rd,
  input  logic [DATA_W-1:0] ex_fwd_data,
  input  logic              mem_fwd_valid,
  input  logic [4:0]        mem_fwd_rd,
  input  logic [DATA_W-1:0] mem_fwd_data,
  ysyx_22041207_id_ex_if.slave bus
);

  logic              vld_p1;
  logic [DATA_W-1:0] pc_p1, imm_p1, csr_p1, rs1_p1, rs2_p1;
  logic [4:0]        operate_p1, rs1_addr_p1, rs2_addr_p1, rd_p1;
  logic [1:0]        sel_a_p1, sel_b_p1;
  logic              rs1to32_p1, rd_wen_p1;

  logic use_rs1, use_rs2, ex_fwd_ok, hazard, capture, hold;

  // A load in EX has no data yet, so it is never a bypass source.
  function automatic logic [DATA_W-1:0] bypass(
    input logic [4:0]        addr,
    input logic [DATA_W-1:0] rf_data,
    input logic              ex_ok,
    input logic [4:0]        ex_rd,
    input logic [DATA_W-1:0] ex_data,
    input logic              mem_ok,
    input logic [4:0]        mem_rd,
    input logic [DATA_W-1:0] mem_data
  );
    if (addr == 5'd0)                  return rf_data;
    else if (ex_ok && ex_rd == addr)   return ex_data;
    else if (mem_ok && mem_rd == addr) return mem_data;
    else                               return rf_data;
  endfunction

  assign use_rs1   = (bus.in_sel_a == 2'd1);
  assign use_rs2   = (bus.in_sel_b == 2'd1);
  assign ex_fwd_ok = ex_fwd_valid & ~ex_fwd_is_load;

  assign hazard = bus.in_valid & ex_fwd_valid & ex_fwd_is_load & (ex_fwd_rd != 5'd0) &
                  ((use_rs1 & (ex_fwd_rd == bus.in_rs1_addr)) |
                   (use_rs2 & (ex_fwd_rd == bus.in_rs2_addr)));

  assign bus.in_ready = ~hazard & (~vld_p1 | ~alu_wait);
  assign capture      = bus.in_valid & bus.in_ready & ~flush;
  assign hold         = vld_p1 & alu_wait;

  // Stage boundary: decode -> execute register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1      <= 1'b0;
      pc_p1       <= '0;
      imm_p1      <= '0;
      csr_p1      <= '0;
      rs1_p1      <= '0;
      rs2_p1      <= '0;
      operate_p1  <= '0;
      rs1_addr_p1 <= '0;
      rs2_addr_p1 <= '0;
      rd_p1       <= '0;
      sel_a_p1    <= '0;
      sel_b_p1    <= '0;
      rs1to32_p1  <= 1'b0;
      rd_wen_p1   <= 1'b0;
    end else begin
      if (flush)          vld_p1 <= 1'b0;
      else if (capture)   vld_p1 <= 1'b1;
      else if (!alu_wait) vld_p1 <= 1'b0;

      if (capture) begin
        pc_p1       <= bus.in_pc;
        imm_p1      <= bus.in_imm;
        csr_p1      <= bus.in_csr;
        operate_p1  <= bus.in_operate;
        rs1_addr_p1 <= bus.in_rs1_addr;
        rs2_addr_p1 <= bus.in_rs2_addr;
        rd_p1       <= bus.in_rd;
        sel_a_p1    <= bus.in_sel_a;
        sel_b_p1    <= bus.in_sel_b;
        rs1to32_p1  <= bus.in_rs1to32;
        rd_wen_p1   <= bus.in_rd_wen;
        rs1_p1      <= bypass(bus.in_rs1_addr, bus.in_rs1_data, ex_fwd_ok, ex_fwd_rd,
                              ex_fwd_data, mem_fwd_valid, mem_fwd_rd, mem_fwd_data);
        rs2_p1      <= bypass(bus.in_rs2_addr, bus.in_rs2_data, ex_fwd_ok, ex_fwd_rd,
                              ex_fwd_data, mem_fwd_valid, mem_fwd_rd, mem_fwd_data);
      end else if (hold) begin
        // A producer reaching MEM while we stall would otherwise be missed.
        if (mem_fwd_valid && mem_fwd_rd != 5'd0 && mem_fwd_rd == rs1_addr_p1)
          rs1_p1 <= mem_fwd_data;
        if (mem_fwd_valid && mem_fwd_rd != 5'd0 && mem_fwd_rd == rs2_addr_p1)
          rs2_p1 <= mem_fwd_data;
      end
    end
  end

  assign bus.out_valid   = vld_p1;
  assign bus.out_pc      = pc_p1;
  assign bus.out_operate = operate_p1;
  assign bus.out_rs1     = rs1_p1;
  assign bus.out_rs2     = rs2_p1;
  assign bus.out_csr     = csr_p1;
  assign bus.out_imm     = imm_p1;
  assign bus.out_sel_a   = sel_a_p1;
  assign bus.out_sel_b   = sel_b_p1;
  assign bus.out_rs1to32 = rs1to32_p1;
  assign bus.out_rd      = rd_p1;
  assign bus.out_rd_wen  = rd_wen_p1 & vld_p1;

endmodule

// File: tb/tb_ysyx_22041207_id_ex.sv
// Bench for the ID/EX register: expected entries are queued as instructions are
// driven and compared when the register presents them.
module tb_ysyx_22041207_id_ex;

  typedef struct packed {
    logic [63:0] pc;
    logic [4:0]  operate;
    logic [63:0] rs1;
    logic [63:0] rs2;
    logic [63:0] csr;
    logic [63:0] imm;
    logic [1:0]  sel_a;
    logic [1:0]  sel_b;
    logic        rs1to32;
    logic [4:0]  rd;
    logic        rd_wen;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush, alu_wait;
  logic        ex_fwd_valid, ex_fwd_is_load, mem_fwd_valid;
  logic [4:0]  ex_fwd_rd, mem_fwd_rd;
  logic [63:0] ex_fwd_data, mem_fwd_data;

  int   n_cmp = 0;
  int   n_fail = 0;
  ent_t exp_q[$];
  ent_t e, got, held;

  ysyx_22041207_id_ex_if #(.DATA_W(64)) b ();

  ysyx_22041207_id_ex #(.DATA_W(64)) dut (
    .clk(clk), .rst(rst), .flush(flush), .alu_wait(alu_wait),
    .ex_fwd_valid(ex_fwd_valid), .ex_fwd_is_load(ex_fwd_is_load),
    .ex_fwd_rd(ex_fwd_rd), .ex_fwd_data(ex_fwd_data),
    .mem_fwd_valid(mem_fwd_valid), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_data(mem_fwd_data),
    .bus(b)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    b.in_valid     = 1'b0;
    flush          = 1'b0;
    alu_wait       = 1'b0;
    ex_fwd_valid   = 1'b0;
    ex_fwd_is_load = 1'b0;
    ex_fwd_rd      = 5'd0;
    ex_fwd_data    = 64'd0;
    mem_fwd_valid  = 1'b0;
    mem_fwd_rd     = 5'd0;
    mem_fwd_data   = 64'd0;
  endtask

  // Non-operand fields are derived from pc so every entry is distinguishable.
  task automatic drive(input logic [63:0] pc, input logic [4:0] r1a, input logic [63:0] r1d,
                       input logic [4:0] r2a, input logic [63:0] r2d, input logic [1:0] sa,
                       input logic [1:0] sb, input logic [4:0] rd, input logic wen);
    b.in_valid    = 1'b1;
    b.in_pc       = pc;
    b.in_operate  = pc[6:2];
    b.in_imm      = {pc[31:0], pc[63:32]};
    b.in_csr      = ~pc;
    b.in_rs1to32  = pc[2];
    b.in_rs1_addr = r1a;
    b.in_rs1_data = r1d;
    b.in_rs2_addr = r2a;
    b.in_rs2_data = r2d;
    b.in_sel_a    = sa;
    b.in_sel_b    = sb;
    b.in_rd       = rd;
    b.in_rd_wen   = wen;
  endtask

  function automatic ent_t mk_exp(input logic [63:0] pc, input logic [63:0] rs1,
                                  input logic [63:0] rs2, input logic [1:0] sa,
                                  input logic [1:0] sb, input logic [4:0] rd, input logic wen);
    ent_t x;
    x.pc = pc; x.operate = pc[6:2]; x.rs1 = rs1; x.rs2 = rs2; x.csr = ~pc;
    x.imm = {pc[31:0], pc[63:32]}; x.sel_a = sa; x.sel_b = sb; x.rs1to32 = pc[2];
    x.rd = rd; x.rd_wen = wen;
    return x;
  endfunction

  function automatic ent_t sample_out();
    ent_t x;
    x.pc = b.out_pc; x.operate = b.out_operate; x.rs1 = b.out_rs1; x.rs2 = b.out_rs2;
    x.csr = b.out_csr; x.imm = b.out_imm; x.sel_a = b.out_sel_a; x.sel_b = b.out_sel_b;
    x.rs1to32 = b.out_rs1to32; x.rd = b.out_rd; x.rd_wen = b.out_rd_wen;
    return x;
  endfunction

  task automatic test_reset();
    set_idle();
    drive(64'h0, 5'd0, 64'd0, 5'd0, 64'd0, 2'd0, 2'd0, 5'd0, 1'b0);
    b.in_valid = 1'b0;
    #2 rst = 1'b1;
    drive(64'h1234, 5'd1, 64'h1, 5'd2, 64'h2, 2'd1, 2'd1, 5'd3, 1'b1);
    #1;
    n_cmp++; if (b.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", b.out_valid); end
    n_cmp++; if (b.out_rd_wen !== 1'b0) begin n_fail++; $display("FAIL reset_rd_wen: got %b want 0", b.out_rd_wen); end
    n_cmp++; if (b.out_pc !== 64'd0) begin n_fail++; $display("FAIL reset_pc: got %h want 0", b.out_pc); end
    n_cmp++; if (b.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", b.in_ready); end
    tick(); tick();
    n_cmp++; if (b.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_no_capture: got %b want 0", b.out_valid); end
    rst = 1'b0;
    set_idle();
    tick();
  endtask

  task automatic test_capture();
    drive(64'h8000_0000, 5'd5, 64'h11, 5'd6, 64'h66, 2'd1, 2'd0, 5'd10, 1'b1);
    exp_q.push_back(mk_exp(64'h8000_0000, 64'h11, 64'h66, 2'd1, 2'd0, 5'd10, 1'b1));
    #1;
    n_cmp++; if (b.in_ready !== 1'b1) begin n_fail++; $display("FAIL cap_ready: got %b want 1", b.in_ready); end
    tick();
    n_cmp++; if (b.out_valid !== 1'b1) begin n_fail++; $display("FAIL cap_valid: got %b want 1", b.out_valid); end
    e = exp_q.pop_front(); got = sample_out();
    n_cmp++; if (got !== e) begin n_fail++; $display("FAIL cap_entry: got %h want %h", got, e); end
    set_idle();
    tick();
    n_cmp++; if (b.out_valid !== 1'b0) begin n_fail++; $display("FAIL bubble_valid: got %b want 0", b.out_valid); end
    n_cmp++; if (b.out_rd_wen !== 1'b0) begin n_fail++; $display("FAIL bubble_rd_wen: got %b want 0", b.out_rd_wen); end
  endtask

  task automatic test_back_to_back_bypass();
    // EX beats MEM on rs1
    drive(64'h8000_0010, 5'd3, 64'h33, 5'd9, 64'h99, 2'd1, 2'd1, 5'd4, 1'b1);
    ex_fwd_valid = 1'b1; ex_fwd_rd = 5'd3; ex_fwd_data = 64'hAA;
    mem_fwd_valid = 1'b1; mem_fwd_rd = 5'd3; mem_fwd_data = 64'hBB;
    exp_q.push_back(mk_exp(64'h8000_0010, 64'hAA, 64'h99, 2'd1, 2'd1, 5'd4, 1'b1));
    tick();
    e = exp_q.pop_front(); got = sample_out();
    n_cmp++; if (got !== e || b.out_valid !== 1'b1) begin n_fail++; $display("FAIL byp_ex: got %h want %h", got, e); end
    // EX invalid: MEM supplies rs1
    drive(64'h8000_0014, 5'd3, 64'h33, 5'd9, 64'h99, 2'd1, 2'd1, 5'd4, 1'b1);
    ex_fwd_valid = 1'b0;
    exp_q.push_back(mk_exp(64'h8000_0014, 64'hBB, 64'h99, 2'd1, 2'd1, 5'd4, 1'b1));
    tick();
    e = exp_q.pop_front(); got = sample_out();
    n_cmp++; if (got !== e || b.out_valid !== 1'b1) begin n_fail++; $display("FAIL byp_mem: got %h want %h", got, e); end
    // x0 is never forwarded even when both bypasses name it
    drive(64'h8000_0018, 5'd0, 64'h33, 5'd9, 64'h99, 2'd1, 2'd1, 5'd4, 1'b1);
    ex_fwd_valid = 1'b1; ex_fwd_rd = 5'd0; mem_fwd_rd = 5'd0;
    exp_q.push_back(mk_exp(64'h8000_0018, 64'h33, 64'h99, 2'd1, 2'd1, 5'd4, 1'b1));
    tick();
    e = exp_q.pop_front(); got = sample_out();
    n_cmp++; if (got !== e || b.out_valid !== 1'b1) begin n_fail++; $display("FAIL byp_x0: got %h want %h", got, e); end
    // rs2 from EX, rs1 from MEM in the same capture
    drive(64'h8000_001C, 5'd12, 64'h1212, 5'd9, 64'h99, 2'd1, 2'd1, 5'd4, 1'b0);
    ex_fwd_rd = 5'd9; ex_fwd_data = 64'hE9; mem_fwd_rd = 5'd12; mem_fwd_data = 64'hC12;
    exp_q.push_back(mk_exp(64'h8000_001C, 64'hC12, 64'hE9, 2'd1, 2'd1, 5'd4, 1'b0));
    tick();
    e = exp_q.pop_front(); got = sample_out();
    n_cmp++; if (got !== e || b.out_valid !== 1'b1) begin n_fail++; $display("FAIL byp_mixed: got %h want %h", got, e); end
    set_idle();
    tick();
  endtask

  task automatic test_stall();
    drive(64'h8000_0100, 5'd4, 64'h44, 5'd8, 64'h88, 2'd1, 2'd1, 5'd13, 1'b1);
    exp_q.push_back(mk_exp(64'h8000_0100, 64'h44, 64'h88, 2'd1, 2'd1, 5'd13, 1'b1));
    tick();
    held = exp_q.pop_front(); got = sample_out();
    n_cmp++; if (got !== held) begin n_fail++; $display("FAIL stall_first: got %h want %h", got, held); end
    drive(64'h8000_0104, 5'd14, 64'hE14, 5'd15, 64'hF15, 2'd1, 2'd1, 5'd16, 1'b1);
    alu_wait = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++; if (b.in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready[%0d]: got %b want 0", i, b.in_ready); end
      tick();
      got = sample_out();
      n_cmp++; if (got !== held || b.out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_frozen[%0d]: got %h want %h", i, got, held); end
    end
    // MEM result for the held rs1 arrives during the stall
    mem_fwd_valid = 1'b1; mem_fwd_rd = 5'd4; mem_fwd_data = 64'h5A5A;
    held.rs1 = 64'h5A5A;
    tick();
    got = sample_out();
    n_cmp++; if (got !== held || b.out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_refresh: got %h want %h", got, held); end
    mem_fwd_valid = 1'b0; alu_wait = 1'b0;
    exp_q.push_back(mk_exp(64'h8000_0104, 64'hE14, 64'hF15, 2'd1, 2'd1, 5'd16, 1'b1));
    #1;
    n_cmp++; if (b.in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_release_ready: got %b want 1", b.in_ready); end
    tick();
    e = exp_q.pop_front(); got = sample_out();
    n_cmp++; if (got !== e || b.out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_next: got %h want %h", got, e); end
    set_idle();
    tick();
  endtask

  task automatic test_load_use();
    // Load target matching only unused sources, or x0, is not a hazard
    drive(64'h8000_0200, 5'd7, 64'h70, 5'd7, 64'h71, 2'd0, 2'd2, 5'd1, 1'b1);
    ex_fwd_valid = 1'b1; ex_fwd_is_load = 1'b1; ex_fwd_rd = 5'd7;
    #1;
    n_cmp++; if (b.in_ready !== 1'b1) begin n_fail++; $display("FAIL lu_unused_src: got %b want 1", b.in_ready); end
    drive(64'h8000_0200, 5'd0, 64'h0, 5'd0, 64'h0, 2'd1, 2'd1, 5'd1, 1'b1);
    ex_fwd_rd = 5'd0;
    #1;
    n_cmp++; if (b.in_ready !== 1'b1) begin n_fail++; $display("FAIL lu_x0: got %b want 1", b.in_ready); end
    set_idle();
    drive(64'h8000_0204, 5'd1, 64'h101, 5'd2, 64'h202, 2'd1, 2'd1, 5'd3, 1'b1);
    exp_q.push_back(mk_exp(64'h8000_0204, 64'h101, 64'h202, 2'd1, 2'd1, 5'd3, 1'b1));
    tick();
    e = exp_q.pop_front(); got = sample_out();
    n_cmp++; if (got !== e || b.out_valid !== 1'b1) begin n_fail++; $display("FAIL lu_prior: got %h want %h", got, e); end
    drive(64'h8000_0208, 5'd2, 64'h22, 5'd7, 64'h77, 2'd0, 2'd1, 5'd11, 1'b1);
    ex_fwd_valid = 1'b1; ex_fwd_is_load = 1'b1; ex_fwd_rd = 5'd7; ex_fwd_data = 64'hBAD;
    #1;
    n_cmp++; if (b.in_ready !== 1'b0) begin n_fail++; $display("FAIL lu_ready: got %b want 0", b.in_ready); end
    tick();
    n_cmp++; if (b.out_valid !== 1'b0 || b.out_rd_wen !== 1'b0) begin n_fail++; $display("FAIL lu_bubble: got valid=%b wen=%b want 0/0", b.out_valid, b.out_rd_wen); end
    ex_fwd_valid = 1'b0; ex_fwd_is_load = 1'b0;
    mem_fwd_valid = 1'b1; mem_fwd_rd = 5'd7; mem_fwd_data = 64'hDD;
    exp_q.push_back(mk_exp(64'h8000_0208, 64'h22, 64'hDD, 2'd0, 2'd1, 5'd11, 1'b1));
    #1;
    n_cmp++; if (b.in_ready !== 1'b1) begin n_fail++; $display("FAIL lu_clear_ready: got %b want 1", b.in_ready); end
    tick();
    e = exp_q.pop_front(); got = sample_out();
    n_cmp++; if (got !== e || b.out_valid !== 1'b1) begin n_fail++; $display("FAIL lu_capture: got %h want %h", got, e); end
    set_idle();
    tick();
  endtask

  task automatic test_flush();
    drive(64'h8000_0300, 5'd1, 64'h1, 5'd2, 64'h2, 2'd1, 2'd1, 5'd5, 1'b1);
    exp_q.push_back(mk_exp(64'h8000_0300, 64'h1, 64'h2, 2'd1, 2'd1, 5'd5, 1'b1));
    tick();
    e = exp_q.pop_front(); got = sample_out();
    n_cmp++; if (got !== e || b.out_valid !== 1'b1) begin n_fail++; $display("FAIL flush_prior: got %h want %h", got, e); end
    drive(64'h8000_0304, 5'd3, 64'h3, 5'd4, 64'h4, 2'd1, 2'd1, 5'd6, 1'b1);
    flush = 1'b1; alu_wait = 1'b1;
    tick();
    n_cmp++; if (b.out_valid !== 1'b0 || b.out_rd_wen !== 1'b0) begin n_fail++; $display("FAIL flush_kill: got valid=%b wen=%b want 0/0", b.out_valid, b.out_rd_wen); end
    set_idle();
    drive(64'h8000_0308, 5'd3, 64'h3, 5'd4, 64'h4, 2'd1, 2'd1, 5'd6, 1'b1);
    flush = 1'b1;
    tick();
    n_cmp++; if (b.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_vs_capture: got %b want 0", b.out_valid); end
    set_idle();
    tick();
  endtask

  task automatic test_async_reset();
    drive(64'h8000_0400, 5'd1, 64'hF1, 5'd2, 64'hF2, 2'd1, 2'd1, 5'd7, 1'b1);
    exp_q.push_back(mk_exp(64'h8000_0400, 64'hF1, 64'hF2, 2'd1, 2'd1, 5'd7, 1'b1));
    tick();
    e = exp_q.pop_front(); got = sample_out();
    n_cmp++; if (got !== e || b.out_valid !== 1'b1) begin n_fail++; $display("FAIL ar_prior: got %h want %h", got, e); end
    set_idle();
    #3 rst = 1'b1;
    #1;
    n_cmp++; if (b.out_valid !== 1'b0 || b.out_rd_wen !== 1'b0) begin n_fail++; $display("FAIL ar_clear_ctrl: got valid=%b wen=%b want 0/0", b.out_valid, b.out_rd_wen); end
    n_cmp++; if (b.out_pc !== 64'd0 || b.out_rs1 !== 64'd0) begin n_fail++; $display("FAIL ar_clear_data: got pc=%h rs1=%h want 0/0", b.out_pc, b.out_rs1); end
    rst = 1'b0;
    drive(64'h8000_0410, 5'd1, 64'hA1, 5'd2, 64'hA2, 2'd1, 2'd1, 5'd8, 1'b1);
    exp_q.push_back(mk_exp(64'h8000_0410, 64'hA1, 64'hA2, 2'd1, 2'd1, 5'd8, 1'b1));
    tick();
    e = exp_q.pop_front(); got = sample_out();
    n_cmp++; if (got !== e || b.out_valid !== 1'b1) begin n_fail++; $display("FAIL ar_first_after: got %h want %h", got, e); end
    // Reset while stalled throws the held entry away
    drive(64'h8000_0414, 5'd1, 64'hB1, 5'd2, 64'hB2, 2'd1, 2'd1, 5'd9, 1'b1);
    alu_wait = 1'b1;
    tick();
    n_cmp++; if (b.out_pc !== 64'h8000_0410 || b.out_valid !== 1'b1) begin n_fail++; $display("FAIL ar_held: got pc=%h valid=%b want 80000410/1", b.out_pc, b.out_valid); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (b.out_valid !== 1'b0) begin n_fail++; $display("FAIL ar_midstall: got %b want 0", b.out_valid); end
    #1 rst = 1'b0;
    drive(64'h8000_0418, 5'd1, 64'hC1, 5'd2, 64'hC2, 2'd1, 2'd1, 5'd10, 1'b1);
    exp_q.push_back(mk_exp(64'h8000_0418, 64'hC1, 64'hC2, 2'd1, 2'd1, 5'd10, 1'b1));
    tick();
    e = exp_q.pop_front(); got = sample_out();
    n_cmp++; if (got !== e || b.out_valid !== 1'b1) begin n_fail++; $display("FAIL ar_release_capture: got %h want %h", got, e); end
    set_idle();
    tick();
  endtask

  initial begin
    test_reset();
    test_capture();
    test_back_to_back_bypass();
    test_stall();
    test_load_use();
    test_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
